// File: rtl/mem_arbiter_if.sv
// Cache/RAM side bundle for mem_arbiter: per-CPU icache/dcache request lanes plus the RAM strobes.
// Vector fields are packed CPU-major; CPU c owns bit c of 1-bit lanes and bits [c*W +: W] of word lanes.
interface mem_arbiter_if #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned W    = 32
);
    logic [CPUS-1:0]   iREN;
    logic [CPUS*W-1:0] iaddr;
    logic [CPUS-1:0]   iwait;
    logic [CPUS*W-1:0] iload;
    logic [CPUS-1:0]   dREN;
    logic [CPUS-1:0]   dWEN;
    logic [CPUS*W-1:0] daddr;
    logic [CPUS*W-1:0] dstore;
    logic [CPUS-1:0]   dwait;
    logic [CPUS*W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [W-1:0]      ramaddr;
    logic [W-1:0]      ramstore;
    logic [W-1:0]      ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates per-CPU icache/dcache requests onto one single-port RAM; data beats instruction, RR within class.
// Define MEMARB_PERF_EN to add dgrant_cnt/igrant_cnt/stall_cnt performance counters.
module mem_arbiter #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned W    = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus,
    output logic         ram_err
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]  dgrant_cnt,
    output logic [31:0]  igrant_cnt,
    output logic [31:0]  stall_cnt
`endif
);
    localparam int unsigned PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic [1:0] {
        RS_FREE   = 2'b00,
        RS_BUSY   = 2'b01,
        RS_ACCESS = 2'b10,
        RS_ERROR  = 2'b11
    } ramstate_t;

    state_t            state_q, state_d;
    logic              cls_d_q, wr_q;
    logic [PW-1:0]     cpu_q, d_rr_q, i_rr_q, next_ptr;
    logic [CPUS-1:0]   dreq;
    logic              pick_found, pick_d, pick_wr;
    logic [PW-1:0]     pick_cpu, idx;
    logic              strobe, done, err_hit;
    logic [W-1:0]      sel_iaddr, sel_daddr, sel_dstore;
    ramstate_t         rs;
    logic [CPUS-1:0]   iwait_c, dwait_c;
    logic [CPUS*W-1:0] iload_c, dload_c;
    logic              ramREN_c, ramWEN_c;
    logic [W-1:0]      ramaddr_c, ramstore_c;

    assign dreq       = bus.dREN | bus.dWEN;
    assign rs         = ramstate_t'(bus.ramstate);
    assign sel_iaddr  = bus.iaddr[cpu_q*W +: W];
    assign sel_daddr  = bus.daddr[cpu_q*W +: W];
    assign sel_dstore = bus.dstore[cpu_q*W +: W];
    assign next_ptr   = (cpu_q == PW'(CPUS - 1)) ? '0 : cpu_q + 1'b1;

    // Data pass runs first so any data request pre-empts every instruction request.
    always_comb begin
        pick_found = 1'b0;
        pick_d     = 1'b0;
        pick_wr    = 1'b0;
        pick_cpu   = '0;
        idx        = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            idx = PW'((32'(d_rr_q) + k) % CPUS);
            if (!pick_found && dreq[idx]) begin
                pick_found = 1'b1;
                pick_d     = 1'b1;
                pick_cpu   = idx;
                pick_wr    = bus.dWEN[idx];
            end
        end
        for (int unsigned k = 0; k < CPUS; k++) begin
            idx = PW'((32'(i_rr_q) + k) % CPUS);
            if (!pick_found && bus.iREN[idx]) begin
                pick_found = 1'b1;
                pick_cpu   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ramREN_c   = 1'b0;
        ramWEN_c   = 1'b0;
        ramaddr_c  = '0;
        ramstore_c = '0;
        iwait_c    = '1;
        dwait_c    = '1;
        iload_c    = '0;
        dload_c    = '0;
        strobe     = 1'b0;
        done       = 1'b0;
        err_hit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) state_d = GRANT;
            end
            GRANT: begin
                // The winner's own strobe gates the whole grant, so a withdrawn request drops the RAM strobes at once.
                strobe = cls_d_q ? (wr_q ? bus.dWEN[cpu_q] : bus.dREN[cpu_q]) : bus.iREN[cpu_q];
                if (!strobe) begin
                    state_d = IDLE;
                end else begin
                    ramREN_c   = !(cls_d_q && wr_q);
                    ramWEN_c   = cls_d_q && wr_q;
                    ramaddr_c  = cls_d_q ? sel_daddr : sel_iaddr;
                    ramstore_c = (cls_d_q && wr_q) ? sel_dstore : '0;
                    if (rs == RS_ACCESS) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        if (cls_d_q) begin
                            dwait_c[cpu_q] = 1'b0;
                            if (!wr_q) dload_c[cpu_q*W +: W] = bus.ramload;
                        end else begin
                            iwait_c[cpu_q]         = 1'b0;
                            iload_c[cpu_q*W +: W]  = bus.ramload;
                        end
                    end else if (rs == RS_ERROR) begin
                        err_hit = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ramREN   = ramREN_c;
    assign bus.ramWEN   = ramWEN_c;
    assign bus.ramaddr  = ramaddr_c;
    assign bus.ramstore = ramstore_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = iload_c;
    assign bus.dload    = dload_c;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cls_d_q <= 1'b0;
            wr_q    <= 1'b0;
            cpu_q   <= '0;
            d_rr_q  <= '0;
            i_rr_q  <= '0;
            ram_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_found) begin
                cls_d_q <= pick_d;
                cpu_q   <= pick_cpu;
                wr_q    <= pick_wr;
            end
            if (done) begin
                if (cls_d_q) d_rr_q <= next_ptr;
                else         i_rr_q <= next_ptr;
            end
            if (err_hit) ram_err <= 1'b1;
        end
    end

`ifdef MEMARB_PERF_EN
    logic any_req;
    assign any_req = (|dreq) | (|bus.iREN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dgrant_cnt <= '0;
            igrant_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (done && cls_d_q)  dgrant_cnt <= dgrant_cnt + 32'd1;
            if (done && !cls_d_q) igrant_cnt <= igrant_cnt + 32'd1;
            if (any_req && !done) stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model with a shadow memory predicts every output each cycle.
// A latency/error-injecting RAM model answers the arbiter; completion logs are pinned by literal expectations.
module tb_mem_arbiter;
    localparam int unsigned CPUS = 2;
    localparam int unsigned W    = 32;

    typedef struct {
        logic        is_d;
        int          cpu;
        logic [31:0] data;
    } ev_t;

    logic CLK = 1'b0;
    logic nRST;
    logic ram_err;
`ifdef MEMARB_PERF_EN
    logic [31:0] dgrant_cnt, igrant_cnt, stall_cnt;
`endif

    mem_arbiter_if #(.CPUS(CPUS), .W(W)) bus ();

    mem_arbiter #(.CPUS(CPUS), .W(W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .ram_err   (ram_err)
`ifdef MEMARB_PERF_EN
        ,
        .dgrant_cnt(dgrant_cnt),
        .igrant_cnt(igrant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // RAM model: LAT busy cycles then ACCESS; err_inject answers ERROR to any strobe.
    logic [31:0] ram [0:255];
    logic        ram_ready = 1'b0;
    int          cnt = 0;
    int          lat;
    logic        err_inject;
    logic        rstrobe;

    always_comb begin
        rstrobe = bus.ramREN | bus.ramWEN;
        if (!rstrobe)        bus.ramstate = 2'b00;
        else if (err_inject) bus.ramstate = 2'b11;
        else if (cnt >= lat) bus.ramstate = 2'b10;
        else                 bus.ramstate = 2'b01;
        bus.ramload = ram[bus.ramaddr[9:2]];
    end

    always @(posedge CLK) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hD000_0000 | (32'(i) << 2);
            ram_ready <= 1'b1;
        end else if (rstrobe && bus.ramstate == 2'b10 && bus.ramWEN) begin
            ram[bus.ramaddr[9:2]] <= bus.ramstore;
        end
        if (!rstrobe || bus.ramstate[1]) cnt <= 0;
        else                             cnt <= cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding transaction and two RR pointers.
    logic        m_busy, m_d, m_wr, m_err;
    int          m_cpu, m_drr, m_irr;
    logic [31:0] shadow [0:255];

    ev_t             log_q[$];
    logic            auto_drop;
    logic            s_ramREN, s_ram_err;
    logic [CPUS-1:0] s_dwait, s_iwait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [CPUS-1:0] mask, input int ptr);
        for (int k = 0; k < int'(CPUS); k++)
            if (mask[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
        return -1;
    endfunction

    task automatic model_cycle();
        logic              eREN, eWEN, held;
        logic [W-1:0]      eaddr, estore, a;
        logic [CPUS-1:0]   eiw, edw;
        logic [CPUS*W-1:0] eil, edl;
        int                w;
        eREN = 1'b0; eWEN = 1'b0; eaddr = '0; estore = '0;
        eiw = '1; edw = '1; eil = '0; edl = '0; held = 1'b0; a = '0;
        if (nRST && m_busy) begin
            held = m_d ? (m_wr ? bus.dWEN[m_cpu] : bus.dREN[m_cpu]) : bus.iREN[m_cpu];
            a    = m_d ? bus.daddr[m_cpu*W +: W] : bus.iaddr[m_cpu*W +: W];
            if (held) begin
                eREN   = !(m_d && m_wr);
                eWEN   = m_d && m_wr;
                eaddr  = a;
                estore = (m_d && m_wr) ? bus.dstore[m_cpu*W +: W] : '0;
                if (bus.ramstate == 2'b10) begin
                    if (m_d) begin
                        edw[m_cpu] = 1'b0;
                        if (!m_wr) edl[m_cpu*W +: W] = shadow[a[9:2]];
                    end else begin
                        eiw[m_cpu] = 1'b0;
                        eil[m_cpu*W +: W] = shadow[a[9:2]];
                    end
                end
            end
        end
        check("ramREN",   bus.ramREN,   eREN);
        check("ramWEN",   bus.ramWEN,   eWEN);
        check("ramaddr",  bus.ramaddr,  eaddr);
        check("ramstore", bus.ramstore, estore);
        check("iwait",    bus.iwait,    eiw);
        check("dwait",    bus.dwait,    edw);
        check("iload",    bus.iload,    eil);
        check("dload",    bus.dload,    edl);
        check("ram_err",  ram_err,      nRST ? m_err : 1'b0);

        if (!nRST) begin
            m_busy = 1'b0; m_d = 1'b0; m_wr = 1'b0; m_err = 1'b0;
            m_cpu = 0; m_drr = 0; m_irr = 0;
        end else if (m_busy) begin
            if (!held) begin
                m_busy = 1'b0;
            end else if (bus.ramstate == 2'b10) begin
                m_busy = 1'b0;
                if (m_d && m_wr) shadow[a[9:2]] = bus.dstore[m_cpu*W +: W];
                if (m_d) m_drr = (m_cpu + 1) % CPUS;
                else     m_irr = (m_cpu + 1) % CPUS;
            end else if (bus.ramstate == 2'b11) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
        end else begin
            w = rr_pick(bus.dREN | bus.dWEN, m_drr);
            if (w >= 0) begin
                m_busy = 1'b1; m_d = 1'b1; m_cpu = w; m_wr = bus.dWEN[w];
            end else begin
                w = rr_pick(bus.iREN, m_irr);
                if (w >= 0) begin
                    m_busy = 1'b1; m_d = 1'b0; m_cpu = w; m_wr = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [CPUS-1:0] dd, di;
        @(negedge CLK);
        model_cycle();
        s_ramREN  = bus.ramREN;
        s_ram_err = ram_err;
        s_dwait   = bus.dwait;
        s_iwait   = bus.iwait;
        dd = '0; di = '0;
        for (int c = 0; c < int'(CPUS); c++) begin
            if (!bus.dwait[c]) begin
                log_q.push_back('{1'b1, c, bus.dload[c*W +: W]});
                dd[c] = 1'b1;
            end
            if (!bus.iwait[c]) begin
                log_q.push_back('{1'b0, c, bus.iload[c*W +: W]});
                di[c] = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        if (auto_drop) begin
            bus.dREN = bus.dREN & ~dd;
            bus.dWEN = bus.dWEN & ~dd;
            bus.iREN = bus.iREN & ~di;
        end
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        for (int i = 0; i < budget && log_q.size() < n; i++) tick();
        check({name, "_count"}, log_q.size(), n);
    endtask

    task automatic expect_ev(input string name, input int i, input logic is_d, input int cpu,
                             input logic [31:0] data);
        if (log_q.size() > i) begin
            check({name, "_cls"},  log_q[i].is_d, is_d);
            check({name, "_cpu"},  log_q[i].cpu,  cpu);
            check({name, "_data"}, log_q[i].data, data);
        end else begin
            check({name, "_present"}, log_q.size(), i + 1);
        end
    endtask

    task automatic do_reset();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        log_q.delete();
    endtask

    initial begin
        nRST = 1'b0;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        lat = 1; err_inject = 1'b0; auto_drop = 1'b1;
        m_busy = 1'b0; m_d = 1'b0; m_wr = 1'b0; m_err = 1'b0;
        m_cpu = 0; m_drr = 0; m_irr = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'hD000_0000 | (32'(i) << 2);

        tick();
        check("rst_ramREN",  s_ramREN,  1'b0);
        check("rst_dwait",   s_dwait,   2'b11);
        check("rst_iwait",   s_iwait,   2'b11);
        check("rst_ram_err", s_ram_err, 1'b0);
        do_reset();

        // Reset while CPU0 holds the grant.
        lat = 3;
        bus.daddr = {32'h0, 32'h20};
        bus.dREN  = 2'b01;
        tick();
        tick();
        check("t1_granted", s_ramREN, 1'b1);
        nRST = 1'b0;
        tick();
        check("t1_ramREN", s_ramREN, 1'b0);
        check("t1_dwait",  s_dwait,  2'b11);
        check("t1_iwait",  s_iwait,  2'b11);
        bus.dREN = '0;
        nRST = 1'b1;
        tick();

        // Data request beats a simultaneous instruction request from the same CPU.
        do_reset();
        lat = 1;
        bus.iaddr = {32'h0, 32'h00};
        bus.daddr = {32'h0, 32'hE0};
        bus.iREN  = 2'b01;
        bus.dREN  = 2'b01;
        wait_log("t2", 2, 30);
        expect_ev("t2_first",  0, 1'b1, 0, 32'hD000_00E0);
        expect_ev("t2_second", 1, 1'b0, 0, 32'hD000_0000);

        // Two CPUs hold writes: strict alternation, then readback.
        do_reset();
        auto_drop  = 1'b0;
        bus.daddr  = {32'h0000_00B8, 32'h0000_00A4};
        bus.dstore = {32'hC4C4_C4C4, 32'hAAAA_BBBB};
        bus.dWEN   = 2'b11;
        wait_log("t3w", 4, 40);
        bus.dWEN   = '0;
        expect_ev("t3_w0", 0, 1'b1, 0, 32'h0);
        expect_ev("t3_w1", 1, 1'b1, 1, 32'h0);
        expect_ev("t3_w2", 2, 1'b1, 0, 32'h0);
        expect_ev("t3_w3", 3, 1'b1, 1, 32'h0);
        log_q.delete();
        auto_drop = 1'b1;
        bus.dREN  = 2'b11;
        wait_log("t3r", 2, 30);
        expect_ev("t3_rd_a4", 0, 1'b1, 0, 32'hAAAA_BBBB);
        expect_ev("t3_rd_b8", 1, 1'b1, 1, 32'hC4C4_C4C4);

        // Withdrawal leaves the data pointer where CPU0's completion put it.
        do_reset();
        bus.daddr = {32'h0000_0040, 32'h0000_0030};
        bus.dREN  = 2'b01;
        wait_log("t4pre", 1, 20);
        log_q.delete();
        lat = 3;
        bus.dREN = 2'b10;
        tick();
        tick();
        check("t4_granted", s_ramREN, 1'b1);
        bus.dREN = 2'b00;
        tick();
        check("t4_dropped", s_ramREN, 1'b0);
        check("t4_no_wait", log_q.size(), 0);
        lat = 1;
        bus.dREN = 2'b11;
        wait_log("t4", 2, 30);
        expect_ev("t4_first",  0, 1'b1, 1, 32'hD000_0040);
        expect_ev("t4_second", 1, 1'b1, 0, 32'hD000_0030);

        // ERROR responses are sticky and retried until the RAM recovers.
        do_reset();
        err_inject = 1'b1;
        bus.daddr  = {32'h0, 32'h10};
        bus.dREN   = 2'b01;
        repeat (6) tick();
        check("t5_ram_err", s_ram_err, 1'b1);
        check("t5_no_done", log_q.size(), 0);
        err_inject = 1'b0;
        wait_log("t5", 1, 20);
        expect_ev("t5_retry", 0, 1'b1, 0, 32'hD000_0010);
        check("t5_err_sticky", s_ram_err, 1'b1);

`ifdef MEMARB_PERF_EN
        do_reset();
        bus.daddr = {32'h0000_0044, 32'h0000_0034};
        bus.iaddr = {32'h0000_0008, 32'h0000_0004};
        bus.dREN  = 2'b11;
        bus.iREN  = 2'b11;
        wait_log("t6a", 4, 40);
        bus.dREN  = 2'b01;
        wait_log("t6b", 5, 20);
        check("t6_dgrant", dgrant_cnt, 32'd3);
        check("t6_igrant", igrant_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
